imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the processor's instruction memory; the producing end of the instruction stream that the controller decodes.
- Receives a byte stream over a valid/ready handshake and assembles 32-bit little-endian words.
- Writes the words sequentially into instruction memory.
- Holds the processor in reset until a complete image has loaded without error.

Parameters:
- ADDR_W, 6, word-address width of instruction memory; capacity MAX_WORDS = 2**ADDR_W.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- imem_we  out  1  one-cycle write strobe.
- imem_addr  out  ADDR_W  word address; byte address = {imem_addr, 2'b00}.
- imem_wdata  out  32  assembled instruction word.
- cpu_rst  out  1  processor reset hold, high except in DONE.
- busy  out  1  high in HDR0, HDR1, DATA, CSUM.
- done  out  1  high in DONE.
- err  out  1  high in ERR.

Behaviour:
- Reset values: state=IDLE, cpu_rst=1, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, byte index=0, word count=0.
- Stream format: 2-byte little-endian word count N, then 4*N data bytes, each word little-endian (first byte = bits 7:0).
- State transitions:
  - IDLE: start -> HDR0.
  - HDR0: on handshake, latch N[7:0] -> HDR1.
  - HDR1: on handshake, latch N[15:8]. N==0 or N>MAX_WORDS -> ERR; otherwise -> DATA.
  - DATA: each handshake shifts a byte into the word assembler at index 0..3. The 4th byte registers imem_wdata and pulses imem_we the following cycle.
  - Address and writes: imem_addr starts at 0 and increments after each write strobe; imem_addr and imem_wdata are stable during the strobe.
  - End of data: after the Nth word's handshake -> DONE (or -> CSUM, see Optional Feature). The last write strobe still issues in the cycle after leaving DATA.
  - DONE, ERR: start -> HDR0, clearing the counters, address, byte index and checksum. All other inputs are ignored.
- in_ready = 1 exactly in HDR0, HDR1, DATA and CSUM; combinational from state only. Back-to-back bytes are accepted at one per cycle with no stalls.
- start outside IDLE, DONE or ERR is ignored.
- in_valid outside busy states is ignored; no byte is consumed.
- Word count register is ADDR_W+1 bits wide; comparison against MAX_WORDS is done at full 16-bit width.
- cpu_rst deasserts in the cycle the state becomes DONE, and reasserts on a restart or on rst.
- rst mid-load: immediate return to IDLE. A partial word is discarded, no strobe is issued, and memory already written is left as is.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined: the data bytes are followed by one checksum byte equal to the XOR of all 4*N data bytes. DATA -> CSUM after the last data byte. In CSUM, on handshake: match -> DONE, mismatch -> ERR.
- Undefined: no CSUM state and no checksum register; DATA -> DONE directly.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum (IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERR);
  - the word width constant 32;
  - the header length constant 2.
- One sub-module, byte_word_packer: accepts a byte and a 2-bit index, holds the 32-bit word, and flags when the 4th byte arrives.

Test Plan:
- N=2, bytes 02 00 | 78 56 34 12 | EF BE AD DE -> imem_we at addr 0 with 0x12345678, then addr 1 with 0xDEADBEEF. done=1 and cpu_rst=0 the cycle after the last handshake (checksum off).
- Header 00 00 -> err=1, cpu_rst=1, no imem_we. Header for N=65 with ADDR_W=6 -> err=1.
- in_valid toggled every other cycle during DATA -> only handshaked bytes are counted; same words and addresses as the continuous case.
- rst pulsed after 2 data bytes of word 1 -> IDLE, no strobe for the partial word. A new start with N=1 writes to addr 0.
- With LOADER_CHECKSUM_EN, N=1, data 01 02 04 08: checksum 0x0F -> done=1; checksum 0x0E -> err=1 with cpu_rst=1. The word is still written to addr 0 in both cases.
- start while busy -> ignored. start in DONE -> cpu_rst=1, busy=1, imem_addr=0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional build macro: LOADER_CHECKSUM_EN (adds a trailing XOR checksum byte).
package imem_loader_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned HDR_LEN = 2;

    // StCsum is only reachable when LOADER_CHECKSUM_EN is defined.
    typedef enum logic [2:0] {
        StIdle,
        StHdr0,
        StHdr1,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master = environment side (byte source, memory sink), slave = loader side.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
);

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

endinterface

// File: rtl/imem_loader_byte_word_packer.sv
// Assembles little-endian 32-bit words from bytes placed at a 2-bit index.
module byte_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic [1:0]        idx,
    input  logic [7:0]        din,
    output logic [WORD_W-1:0] word,
    output logic              last
);

    logic [WORD_W-1:0] word_q;

    // Current word with the incoming byte merged, so the 4th byte is visible immediately.
    always_comb begin
        word = word_q;
        if (en) begin
            word[{idx, 3'b000} +: 8] = din;
        end
        last = en && (idx == 2'd3);
    end

    // Hold the partially assembled word between handshakes.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word_q <= '0;
        end else if (en) begin
            word_q <= word;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: header (16-bit LE word count), then
// LE data words written sequentially; holds the CPU in reset until DONE.
// Optional build macro: LOADER_CHECKSUM_EN (XOR checksum byte after the data).
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         cpu_rst,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int unsigned MAX_WORDS = 1 << ADDR_W;

    state_e            state;
    logic [1:0]        byte_idx;
    logic [7:0]        hdr_lo;
    logic [ADDR_W:0]   word_cnt;
    logic [ADDR_W:0]   words_done;
    logic [ADDR_W:0]   words_next;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [WORD_W-1:0] wdata_r;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    logic              hs;
    logic              can_start;
    logic              pk_en;
    logic              pk_last;
    logic [WORD_W-1:0] pk_word;
    logic [15:0]       hdr_n;
    logic              hdr_bad;

    assign busy      = state inside {StHdr0, StHdr1, StData, StCsum};
    assign done      = (state == StDone);
    assign err       = (state == StErr);
    assign cpu_rst   = (state != StDone);

    assign bus.in_ready   = busy;
    assign bus.imem_we    = we_r;
    assign bus.imem_addr  = addr_r;
    assign bus.imem_wdata = wdata_r;

    assign hs         = bus.in_valid && bus.in_ready;
    assign can_start  = start && (state inside {StIdle, StDone, StErr});
    assign pk_en      = hs && (state == StData);
    assign words_next = words_done + 1'b1;
    // Full 16-bit range check so large counts cannot alias into range.
    assign hdr_n      = {bus.in_data, hdr_lo};
    assign hdr_bad    = (hdr_n == 16'd0) || ({1'b0, hdr_n} > 17'(MAX_WORDS));

    byte_word_packer u_packer (
        .clk   (clk),
        .rst   (rst),
        .clear (can_start),
        .en    (pk_en),
        .idx   (byte_idx),
        .din   (bus.in_data),
        .word  (pk_word),
        .last  (pk_last)
    );

    // Load sequencer: header parse, word counting, write strobe and address stepping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            byte_idx   <= 2'd0;
            hdr_lo     <= 8'd0;
            word_cnt   <= '0;
            words_done <= '0;
            we_r       <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            we_r <= 1'b0;
            // Address advances after each strobe so it is stable during the strobe.
            if (we_r) begin
                addr_r <= addr_r + 1'b1;
            end
            unique case (state)
                StIdle, StDone, StErr: begin
                    if (can_start) begin
                        state      <= StHdr0;
                        byte_idx   <= 2'd0;
                        word_cnt   <= '0;
                        words_done <= '0;
                        addr_r     <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum       <= 8'd0;
`endif
                    end
                end
                StHdr0: begin
                    if (hs) begin
                        hdr_lo <= bus.in_data;
                        state  <= StHdr1;
                    end
                end
                StHdr1: begin
                    if (hs) begin
                        if (hdr_bad) begin
                            state <= StErr;
                        end else begin
                            word_cnt <= hdr_n[ADDR_W:0];
                            state    <= StData;
                        end
                    end
                end
                StData: begin
                    if (hs) begin
                        byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= csum ^ bus.in_data;
`endif
                        if (pk_last) begin
                            we_r       <= 1'b1;
                            wdata_r    <= pk_word;
                            words_done <= words_next;
                            if (words_next == word_cnt) begin
`ifdef LOADER_CHECKSUM_EN
                                state <= StCsum;
`else
                                state <= StDone;
`endif
                            end
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                StCsum: begin
                    if (hs) begin
                        state <= (bus.in_data == csum) ? StDone : StErr;
                    end
                end
`endif
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed sequences, a vector table and
// randomized loads checked against a stream-level model of the expected writes.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned MAX_WORDS = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic cpu_rst, busy, done, err;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bus     (bus),
        .cpu_rst (cpu_rst),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  stream[$];
    logic [31:0] exp_addr[$], exp_data[$];
    logic [31:0] got_addr[$], got_data[$];

    typedef struct {
        int n;
        int gap;
        bit bad_csum;
        bit exp_done;
        bit exp_err;
    } vec_t;
    vec_t vecs[$];

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            got_addr.push_back(32'(bus.imem_addr));
            got_data.push_back(bus.imem_wdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b required %b", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic do_start();
        bus.in_valid = 1'b0;
        start        = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Drive one byte and return just after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && waited < 10) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (bus.in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready=%b required 1", bus.in_ready);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_cycles(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected writes from the stream: word w at address w, little-endian bytes.
    task automatic model_writes();
        int n;
        exp_addr.delete();
        exp_data.delete();
        n = int'(stream[1]) * 256 + int'(stream[0]);
        if (n == 0 || n > int'(MAX_WORDS)) return;
        for (int w = 0; w < n; w++) begin
            int b = HDR_LEN + 4 * w;
            exp_addr.push_back(32'(w));
            exp_data.push_back({stream[b+3], stream[b+2], stream[b+1], stream[b]});
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic add_csum(input bit corrupt);
        logic [7:0] x = 8'h00;
        for (int i = HDR_LEN; i < stream.size(); i++) x ^= stream[i];
        stream.push_back(corrupt ? (x ^ 8'h01) : x);
    endtask
`endif

    task automatic compare_writes(input string tag);
        check32({tag, "_wr_count"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            check32({tag, "_wr_addr"}, got_addr[i], exp_addr[i]);
            check32({tag, "_wr_data"}, got_data[i], exp_data[i]);
        end
    endtask

    task automatic header_for(input int n);
        stream.delete();
        stream.push_back(8'(n % 256));
        stream.push_back(8'(n / 256));
    endtask

    // gap: 0 back-to-back, 1 every other cycle, 2 random 0..2 idle cycles.
    task automatic run_stream(input int gap);
        do_start();
        got_addr.delete();
        got_data.delete();
        foreach (stream[i]) begin
            if (gap == 1 && i > 0) idle_cycles(1);
            if (gap == 2) idle_cycles(int'($urandom_range(0, 2)));
            send_byte(stream[i]);
        end
        idle_cycles(2);
    endtask

    initial begin
        do_reset();

        // Reset state.
        check1("rst_cpu_rst", cpu_rst, 1'b1);
        check1("rst_in_ready", bus.in_ready, 1'b0);
        check1("rst_imem_we", bus.imem_we, 1'b0);
        check32("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
        check32("rst_imem_wdata", bus.imem_wdata, 32'd0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_err", err, 1'b0);

        // Bytes offered while idle are not consumed.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h02;
        repeat (3) @(posedge clk);
        #1;
        check1("idle_valid_busy", busy, 1'b0);
        check32("idle_valid_writes", 32'(got_addr.size()), 32'd0);

        // Reference two-word image, back-to-back bytes.
        stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        model_writes();
        do_start();
        got_addr.delete();
        got_data.delete();
        foreach (stream[i]) send_byte(stream[i]);
        check1("n2_last_we", bus.imem_we, 1'b1);
        check32("n2_last_addr", 32'(bus.imem_addr), 32'd1);
        check32("n2_last_wdata", bus.imem_wdata, 32'hDEADBEEF);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h2A);
`endif
        check1("n2_done", done, 1'b1);
        check1("n2_cpu_rst", cpu_rst, 1'b0);
        idle_cycles(2);
        compare_writes("n2");

        // Restart from DONE.
        do_start();
        got_addr.delete();
        got_data.delete();
        check1("restart_cpu_rst", cpu_rst, 1'b1);
        check1("restart_busy", busy, 1'b1);
        check32("restart_addr", 32'(bus.imem_addr), 32'd0);

        // start while busy is ignored (continuing the load begun above).
        stream = '{8'h01, 8'h00, 8'hC3, 8'hA5, 8'h5A, 8'h3C};
`ifdef LOADER_CHECKSUM_EN
        add_csum(1'b0);
`endif
        model_writes();
        send_byte(stream[0]);
        do_start();
        send_byte(stream[1]);
        send_byte(stream[2]);
        send_byte(stream[3]);
        do_start();
        for (int i = 4; i < stream.size(); i++) send_byte(stream[i]);
        idle_cycles(2);
        check1("busy_start_done", done, 1'b1);
        compare_writes("busy_start");

        // Reset in the middle of word 1: no strobe for the partial word.
        header_for(2);
        for (int i = 0; i < 6; i++) stream.push_back(8'(i + 1));
        do_start();
        got_addr.delete();
        got_data.delete();
        foreach (stream[i]) send_byte(stream[i]);
        do_reset();
        idle_cycles(3);
        check1("midrst_busy", busy, 1'b0);
        check1("midrst_cpu_rst", cpu_rst, 1'b1);
        check32("midrst_writes", 32'(got_addr.size()), 32'd1);
        stream = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
`ifdef LOADER_CHECKSUM_EN
        add_csum(1'b0);
`endif
        model_writes();
        run_stream(0);
        check1("midrst_reload_done", done, 1'b1);
        compare_writes("midrst_reload");

`ifdef LOADER_CHECKSUM_EN
        // Checksum good and bad; the word is written either way.
        stream = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
        model_writes();
        run_stream(0);
        check1("csum_ok_done", done, 1'b1);
        compare_writes("csum_ok");
        stream = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
        model_writes();
        run_stream(0);
        check1("csum_bad_err", err, 1'b1);
        check1("csum_bad_cpu_rst", cpu_rst, 1'b1);
        compare_writes("csum_bad");
`endif

        // Vector table: header count, byte gaps, expected terminal status.
        vecs.push_back('{2,   1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1,   0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{64,  0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{0,   0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{65,  0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{257, 0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{5,   2, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{3,   1, 1'b0, 1'b1, 1'b0});
`ifdef LOADER_CHECKSUM_EN
        vecs.push_back('{3,   2, 1'b1, 1'b0, 1'b1});
`endif
        for (int k = 0; k < 6; k++) begin
            vecs.push_back('{int'($urandom_range(1, 12)), 2, 1'b0, 1'b1, 1'b0});
        end

        foreach (vecs[v]) begin
            header_for(vecs[v].n);
            if (vecs[v].n >= 1 && vecs[v].n <= int'(MAX_WORDS)) begin
                for (int i = 0; i < 4 * vecs[v].n; i++) stream.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
                add_csum(vecs[v].bad_csum);
`endif
            end
            model_writes();
            run_stream(vecs[v].gap);
            check1($sformatf("vec%0d_done", v), done, vecs[v].exp_done);
            check1($sformatf("vec%0d_err", v), err, vecs[v].exp_err);
            check1($sformatf("vec%0d_cpu_rst", v), cpu_rst, !vecs[v].exp_done);
            check1($sformatf("vec%0d_busy", v), busy, 1'b0);
            compare_writes($sformatf("vec%0d", v));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
